// File: rtl/atu_pkg.sv
// atu_pkg: shared types for the ATU sequencing and arbitration front-end
package atu_pkg;
    localparam int ATU_ROW_IDX_W = 8;
    typedef enum logic [1:0] {UNINIT, INIT, READY, PIVOT_WAIT} atu_ctrl_st_e;
    typedef struct packed {
        logic [ATU_ROW_IDX_W-1:0] i;
        logic [ATU_ROW_IDX_W-1:0] j;
    } piv_req_t;
endpackage

// File: rtl/atu_pivot_fifo.sv
// atu_pivot_fifo: synchronous FIFO buffering pivot swap requests ahead of the ATU
module atu_pivot_fifo
    import atu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter type T = piv_req_t,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  T              din,
    output T              dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    T mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign dout = mem[rd_ptr];
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/atu_ctrl.sv
// atu_ctrl: ATU init sequencing, buffered pivot issue and round-robin query arbitration
module atu_ctrl
    import atu_pkg::*;
#(
    parameter int ROW_IDX_W = ATU_ROW_IDX_W,
    parameter int NUM_Q = 2,
    parameter int PF_DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       ctrl_ready,
    output logic                       busy,
    input  logic                       piv_valid,
    input  logic [ROW_IDX_W-1:0]       piv_row_i,
    input  logic [ROW_IDX_W-1:0]       piv_row_j,
    output logic                       piv_ready,
    output logic [CNT_W-1:0]           piv_count,
    input  logic [NUM_Q-1:0]           q_valid,
    input  logic [NUM_Q*ROW_IDX_W-1:0] q_row,
    output logic [NUM_Q-1:0]           q_ready,
    output logic [NUM_Q-1:0]           resp_valid,
    output logic [ROW_IDX_W-1:0]       resp_row,
    output logic                       atu_init_identity,
    input  logic                       atu_init_done,
    output logic                       atu_pivot_req_valid,
    output logic [ROW_IDX_W-1:0]       atu_pivot_row_i,
    output logic [ROW_IDX_W-1:0]       atu_pivot_row_j,
    input  logic                       atu_pivot_req_ready,
    input  logic                       atu_pivot_done,
    output logic                       atu_q_req_valid,
    output logic [ROW_IDX_W-1:0]       atu_q_req_row,
    input  logic                       atu_q_resp_valid,
    input  logic [ROW_IDX_W-1:0]       atu_q_resp_row
);
    localparam int QW = $clog2(NUM_Q);
    typedef struct packed {
        logic [ROW_IDX_W-1:0] i;
        logic [ROW_IDX_W-1:0] j;
    } req_t;
    atu_ctrl_st_e st;
    req_t head;
    logic full, empty, issue, skip, found, grant;
    logic [QW-1:0] rr_ptr, gidx, owner;
    logic [$clog2(PF_DEPTH+1)-1:0] fifo_count;
    atu_pivot_fifo #(.DEPTH(PF_DEPTH), .T(req_t)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(piv_valid && piv_ready),
        .pop(issue || skip),
        .din(req_t'{i: piv_row_i, j: piv_row_j}),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(fifo_count)
    );
    assign piv_ready = !full && st != UNINIT;
    assign ctrl_ready = st == READY;
    assign busy = st == INIT || st == PIVOT_WAIT || fifo_count != '0;
    // degenerate i==j swaps retire locally without touching the ATU
    assign issue = st == READY && !empty && head.i != head.j && atu_pivot_req_ready;
    assign skip = st == READY && !empty && head.i == head.j;
    assign atu_pivot_req_valid = issue;
    assign atu_pivot_row_i = issue ? head.i : '0;
    assign atu_pivot_row_j = issue ? head.j : '0;
    always_comb begin
        found = 1'b0;
        gidx = '0;
        for (int o = 0; o < NUM_Q; o++)
            if (!found && q_valid[QW'((int'(rr_ptr) + o) % NUM_Q)]) begin
                found = 1'b1;
                gidx = QW'((int'(rr_ptr) + o) % NUM_Q);
            end
    end
    // queries wait for the pivot queue to drain so they never see a half-applied batch
    assign grant = st == READY && empty && found;
    assign q_ready = grant ? NUM_Q'(1) << gidx : '0;
    assign atu_q_req_valid = grant;
    assign atu_q_req_row = q_row[int'(gidx) * ROW_IDX_W +: ROW_IDX_W];
    assign resp_valid = atu_q_resp_valid ? NUM_Q'(1) << owner : '0;
    assign resp_row = atu_q_resp_row;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st <= UNINIT;
            atu_init_identity <= 1'b0;
            piv_count <= '0;
            rr_ptr <= '0;
            owner <= '0;
        end else begin
            if (grant) begin
                owner <= gidx;
                rr_ptr <= (int'(gidx) == NUM_Q - 1) ? '0 : gidx + 1'b1;
            end
            case (st)
                UNINIT:
                    if (start) begin
                        st <= INIT;
                        atu_init_identity <= 1'b1;
                    end
                INIT:
                    if (atu_init_done) begin
                        st <= READY;
                        atu_init_identity <= 1'b0;
                        piv_count <= '0;
                    end
                READY: begin
                    if (start && empty) begin
                        st <= INIT;
                        atu_init_identity <= 1'b1;
                    end else if (issue) st <= PIVOT_WAIT;
                    if (skip) piv_count <= piv_count + 1'b1;
                end
                PIVOT_WAIT:
                    if (atu_pivot_done) begin
                        st <= READY;
                        piv_count <= piv_count + 1'b1;
                    end
                default: st <= UNINIT;
            endcase
        end
endmodule

// File: tb/tb_atu_ctrl.sv
// tb_atu_ctrl: scoreboard bench for atu_ctrl with a behavioural ATU model
module tb_atu_ctrl;
    localparam int W = 8;
    localparam int NQ = 2;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic ctrl_ready, busy;
    logic piv_valid = 1'b0;
    logic [W-1:0] piv_row_i = '0, piv_row_j = '0;
    logic piv_ready;
    logic [CW-1:0] piv_count;
    logic [NQ-1:0] q_valid = '0;
    logic [NQ*W-1:0] q_row = '0;
    logic [NQ-1:0] q_ready, resp_valid;
    logic [W-1:0] resp_row;
    logic atu_init_identity, atu_init_done;
    logic atu_pivot_req_valid, atu_pivot_req_ready, atu_pivot_done;
    logic [W-1:0] atu_pivot_row_i, atu_pivot_row_j;
    logic atu_q_req_valid, atu_q_resp_valid;
    logic [W-1:0] atu_q_req_row, atu_q_resp_row;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    atu_ctrl #(.ROW_IDX_W(W), .NUM_Q(NQ), .PF_DEPTH(4), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ctrl_ready(ctrl_ready), .busy(busy),
        .piv_valid(piv_valid), .piv_row_i(piv_row_i), .piv_row_j(piv_row_j),
        .piv_ready(piv_ready), .piv_count(piv_count),
        .q_valid(q_valid), .q_row(q_row), .q_ready(q_ready),
        .resp_valid(resp_valid), .resp_row(resp_row),
        .atu_init_identity(atu_init_identity), .atu_init_done(atu_init_done),
        .atu_pivot_req_valid(atu_pivot_req_valid), .atu_pivot_row_i(atu_pivot_row_i),
        .atu_pivot_row_j(atu_pivot_row_j), .atu_pivot_req_ready(atu_pivot_req_ready),
        .atu_pivot_done(atu_pivot_done),
        .atu_q_req_valid(atu_q_req_valid), .atu_q_req_row(atu_q_req_row),
        .atu_q_resp_valid(atu_q_resp_valid), .atu_q_resp_row(atu_q_resp_row)
    );

    // ATU model: 256-cycle identity init, swap commits on the done cycle, 1-cycle query read
    logic [W-1:0] amap [256];
    logic [W-1:0] mpi, mpj;
    int init_cnt;
    logic block = 1'b0;
    assign atu_pivot_req_ready = !block;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            init_cnt <= 0;
            atu_init_done <= 1'b0;
            atu_pivot_done <= 1'b0;
            atu_q_resp_valid <= 1'b0;
            atu_q_resp_row <= '0;
        end else begin
            atu_init_done <= 1'b0;
            if (atu_init_identity && !atu_init_done) begin
                if (init_cnt == 255) begin
                    atu_init_done <= 1'b1;
                    init_cnt <= 0;
                    for (int r = 0; r < 256; r++) amap[r] <= W'(r);
                end else init_cnt <= init_cnt + 1;
            end else init_cnt <= 0;
            atu_pivot_done <= atu_pivot_req_valid && atu_pivot_req_ready;
            if (atu_pivot_req_valid) begin
                mpi <= atu_pivot_row_i;
                mpj <= atu_pivot_row_j;
            end
            if (atu_pivot_done) begin
                amap[mpi] <= amap[mpj];
                amap[mpj] <= amap[mpi];
            end
            atu_q_resp_valid <= atu_q_req_valid;
            atu_q_resp_row <= amap[atu_q_req_row];
        end

    // reference logical->physical map, updated when a swap is accepted by the controller
    logic [W-1:0] ref_map [256];
    typedef struct {
        logic [NQ-1:0] own;
        logic [W-1:0] row;
        int cyc;
    } exp_t;
    typedef struct {
        logic [W-1:0] i;
        logic [W-1:0] j;
    } pexp_t;
    exp_t sbq[$];
    pexp_t pq[$];

    always @(negedge clk) begin
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            checks++;
            if (resp_valid !== sbq[0].own || resp_row !== sbq[0].row) begin
                errors++;
                $display("FAIL resp: got valid=%b row=%0d, expected valid=%b row=%0d",
                         resp_valid, resp_row, sbq[0].own, sbq[0].row);
            end
            void'(sbq.pop_front());
        end else if (resp_valid !== '0) begin
            checks++;
            errors++;
            $display("FAIL resp_unexpected: got valid=%b, expected none", resp_valid);
        end
        if (atu_pivot_req_valid === 1'b1) begin
            checks++;
            if (pq.size() == 0) begin
                errors++;
                $display("FAIL pivot_unexpected: got (%0d,%0d), expected no issue",
                         atu_pivot_row_i, atu_pivot_row_j);
            end else begin
                if (atu_pivot_row_i !== pq[0].i || atu_pivot_row_j !== pq[0].j) begin
                    errors++;
                    $display("FAIL pivot_order: got (%0d,%0d), expected (%0d,%0d)",
                             atu_pivot_row_i, atu_pivot_row_j, pq[0].i, pq[0].j);
                end
                void'(pq.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_init;
        int hi = 0;
        int n = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (ctrl_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                checks++;
                if (busy !== 1'b1 || atu_init_identity !== 1'b1) begin
                    errors++;
                    $display("FAIL init_entry: got busy=%b identity=%b, expected 1 1", busy, atu_init_identity);
                end
            end
            if (atu_init_identity === 1'b1) hi++;
        end
        checks++;
        if (ctrl_ready !== 1'b1 || hi < 256 || atu_init_identity !== 1'b0 || piv_count !== '0) begin
            errors++;
            $display("FAIL init: got ready=%b identity_cycles=%0d identity=%b count=%0d, expected 1 >=256 0 0",
                     ctrl_ready, hi, atu_init_identity, piv_count);
        end
        for (int r = 0; r < 256; r++) ref_map[r] = W'(r);
        tick();
    endtask

    task automatic query(input int k, input logic [W-1:0] row);
        int n = 0;
        bit got = 0;
        exp_t e;
        q_valid[k] = 1'b1;
        q_row[k*W +: W] = row;
        while (!got && n < 200) begin
            @(negedge clk);
            if (q_ready[k] === 1'b1) begin
                got = 1;
                e.own = NQ'(1 << k);
                e.row = ref_map[row];
                e.cyc = cyc + 1;
                sbq.push_back(e);
            end
            n++;
            tick();
        end
        q_valid[k] = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL query_grant: client %0d got no grant, expected one", k);
        end
    endtask

    task automatic push_piv(input logic [W-1:0] i, input logic [W-1:0] j);
        int n = 0;
        bit ok = 0;
        logic [W-1:0] t;
        piv_valid = 1'b1;
        piv_row_i = i;
        piv_row_j = j;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (piv_ready === 1'b1) begin
                ok = 1;
                t = ref_map[i];
                ref_map[i] = ref_map[j];
                ref_map[j] = t;
                if (i != j) pq.push_back('{i: i, j: j});
            end
            n++;
            tick();
        end
        piv_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL piv_accept: (%0d,%0d) not accepted, expected accept", i, j);
        end
    endtask

    task automatic wait_drain;
        int n = 0;
        while (sbq.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding responses, expected 0", sbq.size());
        end
        tick();
    endtask

    task automatic test_reset;
        q_valid = '1;
        piv_valid = 1'b1;
        piv_row_i = 8'd1;
        piv_row_j = 8'd2;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({ctrl_ready, busy, piv_ready, atu_init_identity, atu_pivot_req_valid, atu_q_req_valid, q_ready} !== '0
            || piv_count !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b prdy=%b id=%b pv=%b qv=%b qr=%b cnt=%0d, expected all 0",
                     ctrl_ready, busy, piv_ready, atu_init_identity, atu_pivot_req_valid, atu_q_req_valid, q_ready, piv_count);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (piv_ready !== 1'b0 || q_ready !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL uninit_idle: got piv_ready=%b q_ready=%b busy=%b, expected 0 0 0", piv_ready, q_ready, busy);
        end
        tick();
        q_valid = '0;
        piv_valid = 1'b0;
        tick();
    endtask

    task automatic test_query_basic;
        run_init();
        query(0, 8'd5);
        wait_drain();
    endtask

    task automatic test_pivot_basic;
        push_piv(8'd2, 8'd7);
        q_valid[0] = 1'b1;
        q_row[0 +: W] = 8'd2;
        @(negedge clk);
        checks++;
        if (q_ready !== '0 || atu_pivot_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL pivot_priority: got q_ready=%b pivot_valid=%b, expected 00 1", q_ready, atu_pivot_req_valid);
        end
        tick();
        query(0, 8'd2);
        query(0, 8'd7);
        wait_drain();
        checks++;
        if (piv_count !== CW'(1)) begin
            errors++;
            $display("FAIL pivot_count1: got %0d, expected 1", piv_count);
        end
    endtask

    task automatic test_skip;
        push_piv(8'd3, 8'd3);
        @(negedge clk);
        checks++;
        if (ctrl_ready !== 1'b1) begin
            errors++;
            $display("FAIL skip_state: got ctrl_ready=%b, expected 1", ctrl_ready);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (piv_count !== CW'(2) || busy !== 1'b0) begin
            errors++;
            $display("FAIL skip_count: got count=%0d busy=%b, expected 2 0", piv_count, busy);
        end
        tick();
    endtask

    task automatic test_rr;
        logic [NQ-1:0] exp;
        exp_t e;
        query(1, 8'd4);
        wait_drain();
        q_valid = 2'b11;
        q_row = {8'd2, 8'd7};
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            exp = (n % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (q_ready !== exp) begin
                errors++;
                $display("FAIL rr_grant%0d: got %b, expected %b", n, q_ready, exp);
            end
            if (q_ready === exp) begin
                e.own = exp;
                e.row = exp[0] ? ref_map[7] : ref_map[2];
                e.cyc = cyc + 1;
                sbq.push_back(e);
            end
            tick();
        end
        q_valid = '0;
        wait_drain();
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] ti [5];
        logic [W-1:0] tj [5];
        int n = 0;
        ti = '{8'd10, 8'd11, 8'd12, 8'd0, 8'd10};
        tj = '{8'd11, 8'd12, 8'd13, 8'd255, 8'd13};
        run_init();
        block = 1'b1;
        for (int k = 0; k < 4; k++) push_piv(ti[k], tj[k]);
        piv_valid = 1'b1;
        piv_row_i = ti[4];
        piv_row_j = tj[4];
        @(negedge clk);
        checks++;
        if (piv_ready !== 1'b0 || busy !== 1'b1 || atu_pivot_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full: got piv_ready=%b busy=%b pivot_valid=%b, expected 0 1 0",
                     piv_ready, busy, atu_pivot_req_valid);
        end
        tick();
        block = 1'b0;
        push_piv(ti[4], tj[4]);
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0 || piv_count !== CW'(5) || pq.size() != 0) begin
            errors++;
            $display("FAIL b2b_retire: got busy=%b count=%0d pending=%0d, expected 0 5 0", busy, piv_count, pq.size());
        end
        tick();
        query(0, 8'd0);
        query(1, 8'd10);
        query(0, 8'd11);
        query(1, 8'd12);
        query(0, 8'd13);
        query(1, 8'd255);
        wait_drain();
    endtask

    task automatic test_reset_mid_init;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        checks++;
        if (atu_init_identity !== 1'b1) begin
            errors++;
            $display("FAIL mid_init_identity: got %b, expected 1", atu_init_identity);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ctrl_ready, busy, piv_ready, atu_init_identity, atu_pivot_req_valid, atu_q_req_valid, resp_valid} !== '0
            || piv_count !== '0) begin
            errors++;
            $display("FAIL async_reset: got rdy=%b busy=%b prdy=%b id=%b pv=%b qv=%b rv=%b cnt=%0d, expected all 0",
                     ctrl_ready, busy, piv_ready, atu_init_identity, atu_pivot_req_valid, atu_q_req_valid, resp_valid, piv_count);
        end
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (ctrl_ready !== 1'b0 || atu_init_identity !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_uninit: got ready=%b identity=%b, expected 0 0", ctrl_ready, atu_init_identity);
        end
        run_init();
        query(0, 8'd9);
        wait_drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_query_basic();
        test_pivot_basic();
        test_skip();
        test_rr();
        test_back_to_back();
        test_reset_mid_init();
        checks++;
        if (sbq.size() != 0 || pq.size() != 0) begin
            errors++;
            $display("FAIL leftovers: got %0d responses and %0d pivots pending, expected 0 0", sbq.size(), pq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
